// File: rtl/mbist_clk_enable_ctrl_if.sv
// Handshake bundle between the BIST controller (master) and the
// memory-BIST clock-enable controller (slave).
interface mbist_clk_enable_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             req;
  logic             busy;
  logic             force_on;
  logic             cnt_clr;
  logic             fe;
  logic             ack;
  logic [1:0]       state;
  logic [CNT_W-1:0] en_cycles;

  modport master (
    output req, busy, force_on, cnt_clr,
    input  fe, ack, state, en_cycles
  );

  modport slave (
    input  req, busy, force_on, cnt_clr,
    output fe, ack, state, en_cycles
  );
endinterface

// File: rtl/mbist_clk_enable_ctrl.sv
// Functional-enable controller for the memory-BIST clock gate: warm-up before
// ack, idle drain before closing the gate, and a saturating enabled-cycle count.
module mbist_clk_enable_ctrl #(
  parameter int WARMUP_CYCLES = 4,
  parameter int IDLE_TIMEOUT  = 16,
  parameter int CNT_W         = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  mbist_clk_enable_ctrl_if.slave bus
);

  localparam int MAX_WAIT = (WARMUP_CYCLES > IDLE_TIMEOUT) ? WARMUP_CYCLES : IDLE_TIMEOUT;
  localparam int CW       = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;
  localparam logic [CW-1:0]    WARMUP_LOAD = CW'(WARMUP_CYCLES - 1);
  localparam logic [CW-1:0]    IDLE_LOAD   = CW'(IDLE_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] EN_MAX      = '1;

  typedef enum logic [1:0] {
    ST_OFF    = 2'd0,
    ST_WARMUP = 2'd1,
    ST_ON     = 2'd2,
    ST_DRAIN  = 2'd3
  } state_e;

  state_e           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             force_q, force_d;
  logic [CNT_W-1:0] en_cycles_q, en_cycles_d;
  logic             fe;

  // Every output is a function of flops only, so nothing combinational reaches the gate cell.
  assign fe            = (state_q != ST_OFF) | force_q;
  assign bus.fe        = fe;
  assign bus.ack       = (state_q == ST_ON);
  assign bus.state     = state_q;
  assign bus.en_cycles = en_cycles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_OFF;
      cnt_q       <= '0;
      force_q     <= 1'b0;
      en_cycles_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      force_q     <= force_d;
      en_cycles_q <= en_cycles_d;
    end
  end

  // Within a state, req wins over busy, which wins over timer expiry.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    force_d = bus.force_on;
    case (state_q)
      ST_OFF: begin
        if (bus.req) begin
          state_d = ST_WARMUP;
          cnt_d   = WARMUP_LOAD;
        end
      end
      ST_WARMUP: begin
        if (!bus.req) begin
          state_d = ST_OFF;
        end else if (cnt_q == '0) begin
          state_d = ST_ON;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_ON: begin
        if (!bus.req && !bus.busy) begin
          state_d = ST_DRAIN;
          cnt_d   = IDLE_LOAD;
        end
      end
      ST_DRAIN: begin
        if (bus.req) begin
          state_d = ST_ON;
        end else if (bus.busy) begin
          cnt_d = IDLE_LOAD;
        end else if (cnt_q == '0) begin
          state_d = ST_OFF;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_OFF;
    endcase
  end

  always_comb begin
    en_cycles_d = en_cycles_q;
    if (bus.cnt_clr) begin
      en_cycles_d = '0;
    end else if (fe && (en_cycles_q != EN_MAX)) begin
      en_cycles_d = en_cycles_q + CNT_W'(1);
    end
  end

endmodule
